// File: rtl/fetch_pkg.sv
// Shared widths, reset PC and prefetch-queue entry layout for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned FETCH_DATA_W   = 8;
  localparam int unsigned FETCH_ADDR_W   = 8;
  localparam int unsigned FETCH_DEPTH    = 4;
  localparam int unsigned FETCH_RESET_PC = 0;
  localparam int unsigned FQ_ENTRY_W     = FETCH_ADDR_W + FETCH_DATA_W;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] data;
  } fq_entry_t;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned fq_cnt_w(input int unsigned depth);
    return $unsigned($clog2(depth)) + 1;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-to-decode instruction handshake: fetch drives valid/data/pc, decode drives ready.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_W = FETCH_DATA_W,
  parameter int unsigned ADDR_W = FETCH_ADDR_W
);

  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;

  modport master (output instr_valid, output instr_data, output instr_pc, input instr_ready);
  modport slave  (input instr_valid, input instr_data, input instr_pc, output instr_ready);

endinterface

// File: rtl/fetch_queue.sv
// Prefetch FIFO with flush and occupancy count; the head is a register that always mirrors
// the oldest stored entry, so decode sees stable data straight from a flop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned W     = FQ_ENTRY_W,
  parameter int unsigned DEPTH = FETCH_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_valid,
  output logic [W-1:0]             head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = fq_cnt_w(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [W-1:0]     head_nxt;
  logic             do_push, do_pop;

  // Next pointers/count; next head bypasses the write port when the new head is being written now.
  always_comb begin
    do_push    = push && !flush;
    do_pop     = pop && !flush && (count != '0);
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    count_nxt  = count;
    head_nxt   = head;
    if (flush) begin
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (do_pop)  rd_ptr_nxt = rd_ptr + PTR_W'(1);
      if (do_push) wr_ptr_nxt = wr_ptr + PTR_W'(1);
      count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
      if (count_nxt != '0)
        head_nxt = (do_push && (wr_ptr == rd_ptr_nxt)) ? push_data : mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head       <= '0;
    end else begin
      rd_ptr     <= rd_ptr_nxt;
      wr_ptr     <= wr_ptr_nxt;
      count      <= count_nxt;
      head_valid <= (count_nxt != '0);
      head       <= head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: self-managed PC, credit-gated reads of a registered-output ROM,
// and a prefetch queue presenting {pc, instruction} to decode. Redirect overrides everything.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_W    = FETCH_DATA_W,
  parameter int unsigned ADDR_W    = FETCH_ADDR_W,
  parameter int unsigned DEPTH     = FETCH_DEPTH,
  parameter int unsigned RESET_PC  = FETCH_RESET_PC,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_if.master           dec
);

  localparam int unsigned ROM_DEPTH = 1 << ADDR_W;
  localparam int unsigned ENTRY_W   = ADDR_W + DATA_W;
  localparam int unsigned CNT_W     = fq_cnt_w(DEPTH);
  localparam int unsigned OCC_W     = CNT_W + 1;

  logic [DATA_W-1:0]  rom [ROM_DEPTH];
  logic [ADDR_W-1:0]  fetch_pc, fetch_pc_nxt, inflight_pc;
  logic               inflight;
  logic [DATA_W-1:0]  rom_data;
  logic               issue, push, pop;
  logic [CNT_W-1:0]   q_count;
  logic               q_valid;
  logic [ENTRY_W-1:0] q_head;

  // ROM default image.
  initial begin
    if (INIT_FILE == "")
      for (int unsigned i = 0; i < ROM_DEPTH; i++) rom[i] = '0;
  end

  // Issue only when the queue has a slot reserved for every outstanding read.
  always_comb begin
    issue        = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    fetch_pc_nxt = fetch_pc;
    if (redirect_valid) begin
      fetch_pc_nxt = redirect_pc;
    end else begin
      issue = fetch_en && ((OCC_W'(q_count) + OCC_W'(inflight)) < OCC_W'(DEPTH));
      push  = inflight;
      pop   = q_valid && dec.instr_ready;
      if (issue) fetch_pc_nxt = fetch_pc + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= ADDR_W'(RESET_PC);
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      fetch_pc <= fetch_pc_nxt;
      inflight <= issue;
      if (issue) inflight_pc <= fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) rom_data <= rom[fetch_pc];
  end

  fetch_queue #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (redirect_valid),
    .push       (push),
    .push_data  ({inflight_pc, rom_data}),
    .pop        (pop),
    .count      (q_count),
    .head_valid (q_valid),
    .head       (q_head)
  );

  // A redirect cycle never transfers, so valid is masked combinationally.
  assign dec.instr_valid = q_valid && !redirect_valid;
  assign dec.instr_pc    = q_head[ENTRY_W-1 -: ADDR_W];
  assign dec.instr_data  = q_head[DATA_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table, mid-stream reset sequence, then randomized
// traffic checked against an expected-PC-stream model. ROM image is a ^ 8'hA5.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       fetch_en = 1'b0;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_pc = '0;

  int checks = 0;
  int errors = 0;

  fetch_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  fetch_unit #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(4), .RESET_PC(0), .INIT_FILE("")
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec            (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fe;
    logic       rv;
    logic [7:0] rpc;
    logic       rdy;
    logic       ev;
    logic [7:0] epc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic fe, input logic rv, input logic [7:0] rpc,
                              input logic rdy, input logic ev, input logic [7:0] epc);
    vec_t r;
    r.fe = fe; r.rv = rv; r.rpc = rpc; r.rdy = rdy; r.ev = ev; r.epc = epc;
    vecs.push_back(r);
  endfunction

  function automatic logic [7:0] img(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic       fe_d1, fe_d2, rv_d1, rv_d2, pv, prdy;
  fq_entry_t  prev_head;
  logic [7:0] exp_pc;

  initial begin
    bus.instr_ready = 1'b0;
    #1;
    for (int i = 0; i < 256; i++) dut.rom[i] = img(8'(i));

    // Directed cycle table, row 0 is the first cycle after reset release.
    add(1,0,8'h00,1,0,8'h00); add(1,0,8'h00,1,0,8'h00);
    for (int i = 0; i < 3; i++)  add(1,0,8'h00,1,1,8'(i));
    for (int i = 0; i < 10; i++) add(1,0,8'h00,0,1,8'h03);
    for (int i = 3; i < 9; i++)  add(1,0,8'h00,1,1,8'(i));
    add(1,1,8'h40,1,0,8'h00); add(1,0,8'h00,1,0,8'h00); add(1,0,8'h00,1,0,8'h00);
    add(1,0,8'h00,1,1,8'h40); add(1,0,8'h00,1,1,8'h41);
    add(1,1,8'hFE,1,0,8'h00); add(1,0,8'h00,1,0,8'h00); add(1,0,8'h00,1,0,8'h00);
    add(1,0,8'h00,1,1,8'hFE); add(1,0,8'h00,1,1,8'hFF);
    add(1,0,8'h00,1,1,8'h00); add(1,0,8'h00,1,1,8'h01);
    add(0,0,8'h00,1,1,8'h02); add(0,0,8'h00,1,1,8'h03);
    add(0,0,8'h00,1,0,8'h00); add(0,0,8'h00,1,0,8'h00);
    add(0,1,8'h10,1,0,8'h00); add(0,0,8'h00,1,0,8'h00); add(0,0,8'h00,1,0,8'h00);
    add(1,0,8'h00,1,0,8'h00); add(1,0,8'h00,1,0,8'h00);
    add(1,0,8'h00,1,1,8'h10); add(1,0,8'h00,1,1,8'h11);

    repeat (2) @(negedge clk);
    check("reset_valid", 32'(bus.instr_valid), 0);
    check("reset_pc",    32'(bus.instr_pc),    0);
    check("reset_data",  32'(bus.instr_data),  0);

    foreach (vecs[i]) begin
      @(negedge clk);
      if (i == 0) reset_n = 1'b1;
      fetch_en        = vecs[i].fe;
      redirect_valid  = vecs[i].rv;
      redirect_pc     = vecs[i].rpc;
      bus.instr_ready = vecs[i].rdy;
      #1;
      check($sformatf("row%0d_valid", i), 32'(bus.instr_valid), 32'(vecs[i].ev));
      if (vecs[i].ev) begin
        check($sformatf("row%0d_pc", i),   32'(bus.instr_pc),   32'(vecs[i].epc));
        check($sformatf("row%0d_data", i), 32'(bus.instr_data), 32'(img(vecs[i].epc)));
      end
    end

    // Reset with a partly full queue and a read in flight, then restart from RESET_PC.
    redirect_valid = 1'b0;
    fetch_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      bus.instr_ready = 1'b0;
    end
    #2 reset_n = 1'b0;
    #1;
    check("midrst_valid", 32'(bus.instr_valid), 0);
    check("midrst_pc",    32'(bus.instr_pc),    0);
    check("midrst_data",  32'(bus.instr_data),  0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) reset_n = 1'b1;
      bus.instr_ready = 1'b1;
      #1;
      check($sformatf("restart%0d_valid", k), 32'(bus.instr_valid), 32'(k >= 2));
      if (k >= 2) begin
        check($sformatf("restart%0d_pc", k),   32'(bus.instr_pc),   32'(k - 2));
        check($sformatf("restart%0d_data", k), 32'(bus.instr_data), 32'(img(8'(k - 2))));
      end
    end

    // Randomized traffic: accepted words must form the consecutive PC stream since the last redirect.
    fe_d1 = 0; fe_d2 = 0; rv_d1 = 0; rv_d2 = 0; pv = 0; prdy = 1;
    prev_head = '0;
    exp_pc = '0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      fetch_en        = ($urandom_range(0, 9) < 8);
      bus.instr_ready = ($urandom_range(0, 9) < 7);
      redirect_valid  = (t == 0) || ($urandom_range(0, 39) == 0);
      redirect_pc     = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom);
      #1;
      if (redirect_valid)
        check("rand_redirect_valid_low", 32'(bus.instr_valid), 0);
      else if (rv_d1 || rv_d2)
        check("rand_post_redirect_empty", 32'(bus.instr_valid), 0);
      else if (fe_d1 && fe_d2)
        check("rand_liveness_valid", 32'(bus.instr_valid), 1);
      if (pv && !prdy && !redirect_valid) begin
        check("rand_stall_valid", 32'(bus.instr_valid), 1);
        check("rand_stall_pc",    32'(bus.instr_pc),    32'(prev_head.pc));
        check("rand_stall_data",  32'(bus.instr_data),  32'(prev_head.data));
      end
      if (bus.instr_valid && bus.instr_ready) begin
        check("rand_xfer_pc",   32'(bus.instr_pc),   32'(exp_pc));
        check("rand_xfer_data", 32'(bus.instr_data), 32'(img(exp_pc)));
        exp_pc = exp_pc + 8'd1;
      end
      if (redirect_valid) exp_pc = redirect_pc;
      pv             = bus.instr_valid;
      prdy           = bus.instr_ready;
      prev_head.pc   = bus.instr_pc;
      prev_head.data = bus.instr_data;
      fe_d2 = fe_d1; fe_d1 = fetch_en;
      rv_d2 = rv_d1; rv_d1 = redirect_valid;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
